turf_acknack_multi_port: RTL and testbench
==========================================

TURF_ACKNACK_MULTI_PORT -- requirements
Module: turf_acknack_multi_port

Interface
REQ-001 Parameter CHECK_BITS, default 64'h800000FF_FFF00000: entry mask (ACK). NACK instance uses 64'h000000FF_FFFFFFFF.
REQ-002 Parameter OPEN_BIT, default 62: forced to 0 in the effective mask MASK; reports open state in the response.
REQ-003 Parameters ALLOW_BIT (63), ADDR_LSB (20), ADDR_BITS (12): position of the allow flag and the address within a masked entry.
REQ-004 Parameter HIST_DEPTH, default 4, power of 2 in 1..16: duplicate-history entries.
REQ-005 Parameter MAX_ENTRIES, default 8: maximum forwarded entries per packet.
REQ-006 aclk  in  1  sole clock; all logic is on the rising edge.
REQ-007 areset  in  1  reset, synchronous, active-high.
REQ-008 event_open_i  in  1  event path open; low clears the history.
REQ-009 s_udphdr_  AXI4S-min target  64  {ip[63:32], port[31:16], len[15:0]}.
REQ-010 s_udpdata_  AXI4S target  64  request entries (tdata/tkeep/tlast).
REQ-011 m_udphdr_  AXI4S-min host  64  {stored ip, stored port, 16'd16}.
REQ-012 m_udpdata_  AXI4S host  64  two-word response; tkeep = 8'hFF.
REQ-013 m_acknack_  AXI4S-min host  16  {masked[ALLOW_BIT], 3'b000, masked[ADDR_LSB +: ADDR_BITS]}.

Function
REQ-014 The block SHALL define masked entry E = s_udpdata_tdata & MASK.
REQ-015 The FSM SHALL have states IDLE, CHECK, FWD, SKIP, DUMP, HDR, RESP0, RESP1. s_udphdr_tready = (state==IDLE).
REQ-016 IDLE: on header handshake, the block SHALL latch ip and port, clear the per-packet counters and first-word flag, and go to CHECK.
REQ-017 CHECK, tvalid high, evaluated in priority order:
- tkeep != FF on the first word -> DUMP (word not consumed).
- tkeep != FF on a later word -> SKIP.
- event_open_i low -> SKIP.
- E hits a valid history entry, or accepted == MAX_ENTRIES -> discard.
- otherwise -> FWD.
REQ-018 Discard SHALL assert tready in the same cycle. On tlast go to HDR, else stay in CHECK.
REQ-019 FWD: m_acknack_tvalid=1 and s_udpdata_tready=m_acknack_tready. On the joint handshake the block SHALL:
- insert E into the history and store E as the last entry;
- increment accepted;
- go to HDR if tlast, else to CHECK.
REQ-020 SKIP and DUMP SHALL hold tready=1. On the tlast beat, SKIP goes to HDR and DUMP goes to IDLE; DUMP sends no response.
REQ-021 HDR SHALL assert m_udphdr_tvalid; on handshake go to RESP0.
REQ-022 RESP0 SHALL send (last & MASK) | (event_open_i << OPEN_BIT) with tlast=0; on handshake go to RESP1.
REQ-023 RESP1 SHALL send {accepted, duplicates, skipped, total} (16 bits each) with tlast=1; on handshake go to IDLE.
REQ-024 Counters SHALL be 16-bit and saturating: total counts every consumed beat, skipped counts SKIP beats plus the MAX_ENTRIES discards.
REQ-025 The history SHALL be a circular buffer with a write pointer that wraps modulo HIST_DEPTH, overwriting the oldest entry. The lookup SHALL be combinational over all valid entries, so duplicates within one packet are caught.
REQ-026 event_open_i low SHALL clear all valid bits and the last entry on the next edge; a clear in the same cycle as an insert wins.
REQ-027 A FWD beat in flight when open falls SHALL complete; the following words SKIP.
REQ-028 s_udpdata_tready SHALL be 0 in IDLE, HDR, RESP0 and RESP1. Latency from the last request handshake to m_udphdr_tvalid SHALL be 1 cycle.

Reset
REQ-029 areset SHALL force, on the next edge, state IDLE, all valid bits 0, write pointer 0, last entry 0, counters 0, ip and port 0.
REQ-030 Out of reset, every tvalid SHALL be 0 and every s_*_tready SHALL be 0 except s_udphdr_tready=1. Reset mid-packet SHALL abandon the packet without a response.

Structure
REQ-031 Package turf_acknack_pkg SHALL hold the state enum, ACK_CHECK_BITS, NACK_CHECK_BITS and RESP_LENGTH=16.
REQ-032 The history SHALL be the sub-module turf_acknack_history: insert, clear, 64-bit lookup, hit output.

Verification
REQ-033 Open, one word 64'hC00000AB_CDE12345, tkeep=FF, tlast:
- acknack = 16'h8CDE;
- RESP0 = 64'hC00000AB_CDE00000;
- RESP1 = {1,0,0,1};
- header length 16.
REQ-034 Three words A, B, A -> two acknacks; RESP1 = {2,1,0,3}.
REQ-035 HIST_DEPTH=4: send 5 distinct entries, then the first again -> the sixth word is forwarded (evicted), total 6 acknacks.
REQ-036 First word tkeep=8'h0F -> no acknack, no header, back to IDLE. Second word partial -> SKIP, response sent with skipped >= 1.
REQ-037 event_open_i low -> 0 acknacks and RESP0 bit 62 = 0. Raising it after the history held X, then sending X -> forwarded.
REQ-038 m_acknack_tready held low for 10 cycles, then areset -> IDLE next edge, no response, history empty.

Source files
------------

// File: rtl/turf_acknack_pkg.sv
// turf_acknack_pkg
//   Shared types and constants for the TURF ACK/NACK request filter:
//   - state_e          : FSM state encoding, also exported on the debug port
//   - ACK_CHECK_BITS   : default entry mask for the ACK instance
//   - NACK_CHECK_BITS  : entry mask for the NACK instance
//   - RESP_LENGTH      : UDP payload length of the two-word response
//   - sat_inc()        : 16-bit saturating increment used by the packet counters
package turf_acknack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_FWD   = 3'd2,
      ST_SKIP  = 3'd3,
      ST_DUMP  = 3'd4,
      ST_HDR   = 3'd5,
      ST_RESP0 = 3'd6,
      ST_RESP1 = 3'd7
   } state_e;

   localparam logic [63:0] ACK_CHECK_BITS  = 64'h800000FF_FFF00000;
   localparam logic [63:0] NACK_CHECK_BITS = 64'h000000FF_FFFFFFFF;
   localparam logic [15:0] RESP_LENGTH     = 16'd16;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/turf_acknack_history.sv
// turf_acknack_history
//   Circular duplicate-history of masked request entries.
//   Ports:
//     aclk, areset : clock, synchronous active-high reset
//     clear_i      : drop every valid bit on the next edge (wins over insert_i)
//     insert_i     : write entry_i at the write pointer, then advance it
//     entry_i      : 64-bit masked entry to store
//     lookup_i     : 64-bit masked entry to search for
//     hit_o        : lookup_i matches some valid entry (combinational)
module turf_acknack_history #(
   parameter int HIST_DEPTH = 4
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        clear_i,
   input  logic        insert_i,
   input  logic [63:0] entry_i,
   input  logic [63:0] lookup_i,
   output logic        hit_o
);

   localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

   logic [63:0]           entry_q [HIST_DEPTH];
   logic [HIST_DEPTH-1:0] valid_q;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_d;

   // Pointer wraps at HIST_DEPTH so the oldest entry is overwritten next.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (wr_ptr_q == PTR_W'(HIST_DEPTH - 1)) begin
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
      end else if (clear_i) begin
         valid_q  <= '0;
      end else if (insert_i) begin
         valid_q[wr_ptr_q] <= 1'b1;
         wr_ptr_q          <= wr_ptr_d;
      end
   end

   // Entry storage needs no reset: it is qualified by valid_q.
   always_ff @(posedge aclk) begin
      if (insert_i && !clear_i && !areset) begin
         entry_q[wr_ptr_q] <= entry_i;
      end
   end

   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i] == lookup_i)) begin
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/turf_acknack_multi_port.sv
// turf_acknack_multi_port
//   Filters a packet of 64-bit ACK/NACK request entries: each entry is masked,
//   checked against a duplicate history and forwarded as a 16-bit acknack word.
//   After the packet a UDP header plus a two-word response (last forwarded
//   entry, then packet counters) is returned to the sender.
//   Ports:
//     aclk, areset       : clock, synchronous active-high reset
//     event_open_i       : event path open; low clears the history
//     s_udphdr_*         : incoming header {ip, port, len}
//     s_udpdata_*        : incoming request entries
//     m_udphdr_*         : response header {ip, port, RESP_LENGTH}
//     m_udpdata_*        : two-word response
//     m_acknack_*        : forwarded acknack words
//     dbg_state_o        : current FSM state
//   Handshakes: a transfer happens on a rising edge where tvalid and tready
//   are both high; a host holds tvalid and tdata stable until that edge.
module turf_acknack_multi_port
   import turf_acknack_pkg::*;
#(
   parameter logic [63:0] CHECK_BITS  = ACK_CHECK_BITS,
   parameter int          OPEN_BIT    = 62,
   parameter int          ALLOW_BIT   = 63,
   parameter int          ADDR_LSB    = 20,
   parameter int          ADDR_BITS   = 12,
   parameter int          HIST_DEPTH  = 4,
   parameter int          MAX_ENTRIES = 8
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        event_open_i,
   input  logic [63:0] s_udphdr_tdata,
   input  logic        s_udphdr_tvalid,
   output logic        s_udphdr_tready,
   input  logic [63:0] s_udpdata_tdata,
   input  logic [7:0]  s_udpdata_tkeep,
   input  logic        s_udpdata_tlast,
   input  logic        s_udpdata_tvalid,
   output logic        s_udpdata_tready,
   output logic [63:0] m_udphdr_tdata,
   output logic        m_udphdr_tvalid,
   input  logic        m_udphdr_tready,
   output logic [63:0] m_udpdata_tdata,
   output logic [7:0]  m_udpdata_tkeep,
   output logic        m_udpdata_tlast,
   output logic        m_udpdata_tvalid,
   input  logic        m_udpdata_tready,
   output logic [15:0] m_acknack_tdata,
   output logic        m_acknack_tvalid,
   input  logic        m_acknack_tready,
   output state_e      dbg_state_o
);

   // The open bit is reported separately, so it never takes part in matching.
   localparam logic [63:0] MASK = CHECK_BITS & ~(64'd1 << OPEN_BIT);

   state_e      state_q, state_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] port_q, port_d;
   logic        first_q, first_d;
   logic [15:0] accepted_q, accepted_d;
   logic [15:0] dup_q, dup_d;
   logic [15:0] skipped_q, skipped_d;
   logic [15:0] total_q, total_d;
   logic [63:0] last_q;
   logic [63:0] entry_e;
   logic        hist_hit;
   logic        hist_insert;
   logic        unused_hdr_len;

   assign entry_e         = s_udpdata_tdata & MASK;
   assign unused_hdr_len  = ^s_udphdr_tdata[15:0];
   assign s_udphdr_tready = (state_q == ST_IDLE);
   assign m_udphdr_tdata  = {ip_q, port_q, RESP_LENGTH};
   assign m_udpdata_tkeep = 8'hFF;
   assign m_acknack_tdata = {entry_e[ALLOW_BIT], 3'b000, entry_e[ADDR_LSB +: ADDR_BITS]};
   assign dbg_state_o     = state_q;

   turf_acknack_history #(
      .HIST_DEPTH(HIST_DEPTH)
   ) u_history (
      .aclk     (aclk),
      .areset   (areset),
      .clear_i  (!event_open_i),
      .insert_i (hist_insert),
      .entry_i  (entry_e),
      .lookup_i (entry_e),
      .hit_o    (hist_hit)
   );

   always_comb begin
      state_d          = state_q;
      ip_d             = ip_q;
      port_d           = port_q;
      first_d          = first_q;
      accepted_d       = accepted_q;
      dup_d            = dup_q;
      skipped_d        = skipped_q;
      total_d          = total_q;
      hist_insert      = 1'b0;
      s_udpdata_tready = 1'b0;
      m_acknack_tvalid = 1'b0;
      m_udphdr_tvalid  = 1'b0;
      m_udpdata_tvalid = 1'b0;
      m_udpdata_tdata  = '0;
      m_udpdata_tlast  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_udphdr_tvalid) begin
               ip_d       = s_udphdr_tdata[63:32];
               port_d     = s_udphdr_tdata[31:16];
               first_d    = 1'b1;
               accepted_d = '0;
               dup_d      = '0;
               skipped_d  = '0;
               total_d    = '0;
               state_d    = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (s_udpdata_tvalid) begin
               if (s_udpdata_tkeep != 8'hFF) begin
                  // A malformed first word means the whole packet is bogus.
                  state_d = first_q ? ST_DUMP : ST_SKIP;
               end else if (!event_open_i) begin
                  state_d = ST_SKIP;
               end else if (hist_hit || (accepted_q == 16'(MAX_ENTRIES))) begin
                  // Discard consumes the word right here.
                  s_udpdata_tready = 1'b1;
                  first_d          = 1'b0;
                  total_d          = sat_inc(total_q);
                  if (hist_hit) begin
                     dup_d = sat_inc(dup_q);
                  end else begin
                     skipped_d = sat_inc(skipped_q);
                  end
                  if (s_udpdata_tlast) begin
                     state_d = ST_HDR;
                  end
               end else begin
                  state_d = ST_FWD;
               end
            end
         end

         ST_FWD: begin
            m_acknack_tvalid = 1'b1;
            s_udpdata_tready = m_acknack_tready;
            if (s_udpdata_tvalid && m_acknack_tready) begin
               hist_insert = 1'b1;
               first_d     = 1'b0;
               accepted_d  = sat_inc(accepted_q);
               total_d     = sat_inc(total_q);
               state_d     = s_udpdata_tlast ? ST_HDR : ST_CHECK;
            end
         end

         ST_SKIP: begin
            s_udpdata_tready = 1'b1;
            if (s_udpdata_tvalid) begin
               first_d   = 1'b0;
               skipped_d = sat_inc(skipped_q);
               total_d   = sat_inc(total_q);
               if (s_udpdata_tlast) begin
                  state_d = ST_HDR;
               end
            end
         end

         ST_DUMP: begin
            s_udpdata_tready = 1'b1;
            if (s_udpdata_tvalid) begin
               first_d = 1'b0;
               total_d = sat_inc(total_q);
               if (s_udpdata_tlast) begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_HDR: begin
            m_udphdr_tvalid = 1'b1;
            if (m_udphdr_tready) begin
               state_d = ST_RESP0;
            end
         end

         ST_RESP0: begin
            m_udpdata_tvalid = 1'b1;
            m_udpdata_tdata  = last_q | (64'(event_open_i) << OPEN_BIT);
            if (m_udpdata_tready) begin
               state_d = ST_RESP1;
            end
         end

         ST_RESP1: begin
            m_udpdata_tvalid = 1'b1;
            m_udpdata_tlast  = 1'b1;
            m_udpdata_tdata  = {accepted_q, dup_q, skipped_q, total_q};
            if (m_udpdata_tready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         ip_q       <= '0;
         port_q     <= '0;
         first_q    <= 1'b0;
         accepted_q <= '0;
         dup_q      <= '0;
         skipped_q  <= '0;
         total_q    <= '0;
      end else begin
         state_q    <= state_d;
         ip_q       <= ip_d;
         port_q     <= port_d;
         first_q    <= first_d;
         accepted_q <= accepted_d;
         dup_q      <= dup_d;
         skipped_q  <= skipped_d;
         total_q    <= total_d;
      end
   end

   // Closing the event path also forgets the last forwarded entry.
   always_ff @(posedge aclk) begin
      if (areset || !event_open_i) begin
         last_q <= '0;
      end else if (hist_insert) begin
         last_q <= entry_e;
      end
   end

endmodule

// File: tb/tb_turf_acknack_multi_port.sv
module tb_turf_acknack_multi_port;
   import turf_acknack_pkg::*;

   // clock / reset
   logic aclk = 1'b0;
   always #5 aclk = ~aclk;
   logic areset;

   logic        event_open_i;
   logic [63:0] s_udphdr_tdata;
   logic        s_udphdr_tvalid, s_udphdr_tready;
   logic [63:0] s_udpdata_tdata;
   logic [7:0]  s_udpdata_tkeep;
   logic        s_udpdata_tlast, s_udpdata_tvalid, s_udpdata_tready;
   logic [63:0] m_udphdr_tdata;
   logic        m_udphdr_tvalid, m_udphdr_tready;
   logic [63:0] m_udpdata_tdata;
   logic [7:0]  m_udpdata_tkeep;
   logic        m_udpdata_tlast, m_udpdata_tvalid, m_udpdata_tready;
   logic [15:0] m_acknack_tdata;
   logic        m_acknack_tvalid, m_acknack_tready;
   state_e      dbg_state;

   turf_acknack_multi_port dut (
      .aclk             (aclk),
      .areset           (areset),
      .event_open_i     (event_open_i),
      .s_udphdr_tdata   (s_udphdr_tdata),
      .s_udphdr_tvalid  (s_udphdr_tvalid),
      .s_udphdr_tready  (s_udphdr_tready),
      .s_udpdata_tdata  (s_udpdata_tdata),
      .s_udpdata_tkeep  (s_udpdata_tkeep),
      .s_udpdata_tlast  (s_udpdata_tlast),
      .s_udpdata_tvalid (s_udpdata_tvalid),
      .s_udpdata_tready (s_udpdata_tready),
      .m_udphdr_tdata   (m_udphdr_tdata),
      .m_udphdr_tvalid  (m_udphdr_tvalid),
      .m_udphdr_tready  (m_udphdr_tready),
      .m_udpdata_tdata  (m_udpdata_tdata),
      .m_udpdata_tkeep  (m_udpdata_tkeep),
      .m_udpdata_tlast  (m_udpdata_tlast),
      .m_udpdata_tvalid (m_udpdata_tvalid),
      .m_udpdata_tready (m_udpdata_tready),
      .m_acknack_tdata  (m_acknack_tdata),
      .m_acknack_tvalid (m_acknack_tvalid),
      .m_acknack_tready (m_acknack_tready),
      .dbg_state_o      (dbg_state)
   );

   // scoreboard
   int compared   = 0;
   int mismatched = 0;
   logic [15:0] exp_ack_q[$];
   logic [15:0] got_ack_q[$];
   logic [63:0] exp_hdr_q[$];
   logic [63:0] got_hdr_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] got_data_q[$];
   logic        got_last_q[$];
   logic [7:0]  got_keep_q[$];

   // Handshakes are taken on the falling edge: inputs are stable there and
   // equal to what the next rising edge samples.
   always @(negedge aclk) begin
      if (!areset) begin
         if (m_acknack_tvalid && m_acknack_tready) got_ack_q.push_back(m_acknack_tdata);
         if (m_udphdr_tvalid && m_udphdr_tready) got_hdr_q.push_back(m_udphdr_tdata);
         if (m_udpdata_tvalid && m_udpdata_tready) begin
            got_data_q.push_back(m_udpdata_tdata);
            got_last_q.push_back(m_udpdata_tlast);
            got_keep_q.push_back(m_udpdata_tkeep);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks (all start and end 1 time unit after a rising edge)
   task automatic send_hdr(input logic [63:0] d);
      int n; logic done;
      n = 0; done = 1'b0;
      s_udphdr_tdata = d; s_udphdr_tvalid = 1'b1;
      while (!done && n < 64) begin
         @(negedge aclk);
         if (s_udphdr_tready === 1'b1) done = 1'b1;
         @(posedge aclk); #1;
         n++;
      end
      s_udphdr_tvalid = 1'b0;
      chk("hdr_accepted", {63'd0, done}, 64'd1);
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n; logic done;
      n = 0; done = 1'b0;
      s_udpdata_tdata = d; s_udpdata_tkeep = k; s_udpdata_tlast = l;
      s_udpdata_tvalid = 1'b1;
      while (!done && n < 64) begin
         @(negedge aclk);
         if (s_udpdata_tready === 1'b1) done = 1'b1;
         @(posedge aclk); #1;
         n++;
      end
      s_udpdata_tvalid = 1'b0;
      chk("beat_accepted", {63'd0, done}, 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n; logic done;
      n = 0; done = 1'b0;
      while (!done && n < 64) begin
         @(negedge aclk);
         if (dbg_state === ST_IDLE) done = 1'b1;
         n++;
      end
      @(posedge aclk); #1;
      chk({tag, "_idle"}, {63'd0, done}, 64'd1);
   endtask

   task automatic check_acks(input string tag);
      chk({tag, "_ack_count"}, 64'(got_ack_q.size()), 64'(exp_ack_q.size()));
      for (int i = 0; i < exp_ack_q.size() && i < got_ack_q.size(); i++)
         chk($sformatf("%s_ack%0d", tag, i), 64'(got_ack_q[i]), 64'(exp_ack_q[i]));
      got_ack_q.delete(); exp_ack_q.delete();
   endtask

   task automatic check_resp(input string tag);
      chk({tag, "_hdr_count"}, 64'(got_hdr_q.size()), 64'(exp_hdr_q.size()));
      for (int i = 0; i < exp_hdr_q.size() && i < got_hdr_q.size(); i++)
         chk($sformatf("%s_hdr%0d", tag, i), got_hdr_q[i], exp_hdr_q[i]);
      chk({tag, "_data_count"}, 64'(got_data_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
         chk($sformatf("%s_resp%0d", tag, i), got_data_q[i], exp_q[i]);
         chk($sformatf("%s_last%0d", tag, i), {63'd0, got_last_q[i]}, {63'd0, (i % 2) == 1});
         chk($sformatf("%s_keep%0d", tag, i), 64'(got_keep_q[i]), 64'hFF);
      end
      got_hdr_q.delete(); exp_hdr_q.delete();
      got_data_q.delete(); got_last_q.delete(); got_keep_q.delete(); exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1; event_open_i = 1'b1;
      s_udphdr_tdata = '0; s_udphdr_tvalid = 1'b0;
      s_udpdata_tdata = '0; s_udpdata_tkeep = 8'hFF;
      s_udpdata_tlast = 1'b0; s_udpdata_tvalid = 1'b0;
      m_udphdr_tready = 1'b1; m_udpdata_tready = 1'b1; m_acknack_tready = 1'b1;

      // reset state
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("rst_hdr_tready", {63'd0, s_udphdr_tready}, 64'd1);
      chk("rst_data_tready", {63'd0, s_udpdata_tready}, 64'd0);
      chk("rst_ack_tvalid", {63'd0, m_acknack_tvalid}, 64'd0);
      chk("rst_hdr_tvalid", {63'd0, m_udphdr_tvalid}, 64'd0);
      chk("rst_data_tvalid", {63'd0, m_udpdata_tvalid}, 64'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(posedge aclk); #1;

      // single entry, open
      send_hdr(64'h0A000001_1234_0008);
      send_beat(64'hC00000AB_CDE12345, 8'hFF, 1'b1);
      @(negedge aclk);
      chk("hdr_latency", {63'd0, m_udphdr_tvalid}, 64'd1);
      wait_idle("single");
      exp_ack_q.push_back(16'h8CDE);
      exp_hdr_q.push_back(64'h0A000001_1234_0010);
      exp_q.push_back(64'hC00000AB_CDE00000);
      exp_q.push_back(64'h0001_0000_0000_0001);
      check_acks("single");
      check_resp("single");

      // A, B, A (second A differs only in masked-off bits)
      send_hdr(64'h0A000002_2222_0018);
      send_beat(64'h80000012_345FFFFF, 8'hFF, 1'b0);
      send_beat(64'h00000056_78900000, 8'hFF, 1'b0);
      send_beat(64'h80000012_34500001, 8'hFF, 1'b1);
      wait_idle("dup");
      exp_ack_q.push_back(16'h8345);
      exp_ack_q.push_back(16'h0789);
      exp_hdr_q.push_back(64'h0A000002_2222_0010);
      exp_q.push_back(64'h40000056_78900000);
      exp_q.push_back(64'h0002_0001_0000_0003);
      check_acks("dup");
      check_resp("dup");

      // empty the history, then 5 distinct + first again (evicted)
      event_open_i = 1'b0;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      event_open_i = 1'b1;
      send_hdr(64'h0A000003_3333_0030);
      for (int i = 0; i < 5; i++) begin
         send_beat(64'h000000A0_00000000 | (64'(i + 1) << 20), 8'hFF, 1'b0);
         exp_ack_q.push_back(16'(i + 1));
      end
      send_beat(64'h000000A0_00100000, 8'hFF, 1'b1);
      exp_ack_q.push_back(16'h0001);
      wait_idle("evict");
      exp_hdr_q.push_back(64'h0A000003_3333_0010);
      exp_q.push_back(64'h400000A0_00100000);
      exp_q.push_back(64'h0006_0000_0000_0006);
      check_acks("evict");
      check_resp("evict");

      // 10 distinct entries: only MAX_ENTRIES=8 forwarded
      send_hdr(64'h0A000004_4444_0050);
      for (int i = 1; i <= 10; i++) begin
         send_beat(64'h000000B0_00000000 | (64'(i) << 20), 8'hFF, i == 10);
         if (i <= 8) exp_ack_q.push_back(16'(i));
      end
      wait_idle("max");
      exp_hdr_q.push_back(64'h0A000004_4444_0010);
      exp_q.push_back(64'h400000B0_00800000);
      exp_q.push_back(64'h0008_0000_0002_000A);
      check_acks("max");
      check_resp("max");

      // partial first word: packet dumped, no response
      send_hdr(64'h0A000005_5555_0010);
      send_beat(64'h000000C0_00900000, 8'h0F, 1'b0);
      send_beat(64'h000000C0_00A00000, 8'hFF, 1'b1);
      wait_idle("dump");
      repeat (4) @(posedge aclk);
      #1;
      check_acks("dump");
      check_resp("dump");

      // partial second word: skipped, response sent
      send_hdr(64'h0A000006_6666_0010);
      send_beat(64'h000000C0_00100000, 8'hFF, 1'b0);
      send_beat(64'h000000C0_00200000, 8'h3F, 1'b1);
      wait_idle("skip");
      exp_ack_q.push_back(16'h0001);
      exp_hdr_q.push_back(64'h0A000006_6666_0010);
      exp_q.push_back(64'h400000C0_00100000);
      exp_q.push_back(64'h0001_0000_0001_0002);
      check_acks("skip");
      check_resp("skip");

      // X forwarded while open
      send_hdr(64'h0A000007_7777_0008);
      send_beat(64'h000000D0_00500000, 8'hFF, 1'b1);
      wait_idle("open1");
      exp_ack_q.push_back(16'h0005);
      exp_hdr_q.push_back(64'h0A000007_7777_0010);
      exp_q.push_back(64'h400000D0_00500000);
      exp_q.push_back(64'h0001_0000_0000_0001);
      check_acks("open1");
      check_resp("open1");

      // closed: everything skipped, RESP0 carries neither last nor open bit
      event_open_i = 1'b0;
      @(posedge aclk); #1;
      send_hdr(64'h0A000008_8888_0010);
      send_beat(64'h000000D0_00500000, 8'hFF, 1'b0);
      send_beat(64'h000000D0_00600000, 8'hFF, 1'b1);
      wait_idle("closed");
      exp_hdr_q.push_back(64'h0A000008_8888_0010);
      exp_q.push_back(64'h0000000000000000);
      exp_q.push_back(64'h0000_0000_0002_0002);
      check_acks("closed");
      check_resp("closed");

      // reopened: X forwarded again since the history was cleared
      event_open_i = 1'b1;
      @(posedge aclk); #1;
      send_hdr(64'h0A000009_9999_0008);
      send_beat(64'h000000D0_00500000, 8'hFF, 1'b1);
      wait_idle("reopen");
      exp_ack_q.push_back(16'h0005);
      exp_hdr_q.push_back(64'h0A000009_9999_0010);
      exp_q.push_back(64'h400000D0_00500000);
      exp_q.push_back(64'h0001_0000_0000_0001);
      check_acks("reopen");
      check_resp("reopen");

      // Z into the history
      send_hdr(64'h0A00000A_AAAA_0008);
      send_beat(64'h000000E0_00700000, 8'hFF, 1'b1);
      wait_idle("z1");
      exp_ack_q.push_back(16'h0007);
      exp_hdr_q.push_back(64'h0A00000A_AAAA_0010);
      exp_q.push_back(64'h400000E0_00700000);
      exp_q.push_back(64'h0001_0000_0000_0001);
      check_acks("z1");
      check_resp("z1");

      // acknack stalled, then reset mid-packet
      m_acknack_tready = 1'b0;
      send_hdr(64'h0A00000B_BBBB_0008);
      s_udpdata_tdata = 64'h000000E0_00800000; s_udpdata_tkeep = 8'hFF;
      s_udpdata_tlast = 1'b1; s_udpdata_tvalid = 1'b1;
      repeat (10) @(posedge aclk);
      @(negedge aclk);
      chk("stall_state", 64'(dbg_state), 64'(ST_FWD));
      chk("stall_ack_tvalid", {63'd0, m_acknack_tvalid}, 64'd1);
      chk("stall_data_tready", {63'd0, s_udpdata_tready}, 64'd0);
      @(posedge aclk); #1;
      areset = 1'b1;
      @(posedge aclk); #1;
      chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("midrst_hdr_tready", {63'd0, s_udphdr_tready}, 64'd1);
      areset = 1'b0; s_udpdata_tvalid = 1'b0; m_acknack_tready = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
      check_acks("midrst");
      check_resp("midrst");

      // Z forwarded again: reset emptied the history
      send_hdr(64'h0A00000C_CCCC_0008);
      send_beat(64'h000000E0_00700000, 8'hFF, 1'b1);
      wait_idle("z2");
      exp_ack_q.push_back(16'h0007);
      exp_hdr_q.push_back(64'h0A00000C_CCCC_0010);
      exp_q.push_back(64'h400000E0_00700000);
      exp_q.push_back(64'h0001_0000_0000_0001);
      check_acks("z2");
      check_resp("z2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
